// File: rtl/fp_div_iter.sv
// -----------------------------------------------------------------------------
// fp_div_iter
// Multi-cycle IEEE-754-style floating-point divider. The mantissa core is a
// restoring shift-subtract loop that produces one quotient bit per clock.
// The result is rounded to nearest-even. Subnormal inputs are flushed to zero,
// and the divider never produces a subnormal output.
//
// Parameters
//   EXP_W : exponent field width (BIAS = 2^(EXP_W-1)-1 is derived)
//   MAN_W : stored fraction width (the hidden bit is implicit)
//   W     : 1+EXP_W+MAN_W, derived and not overridable
//
// Ports
//   clk       in  1   rising-edge clock
//   rst       in  1   synchronous reset, active-high
//   start     in  1   request, sampled only while busy=0 (IDLE or DONE)
//   operand_a in  W   dividend {sign, exponent, fraction}
//   operand_b in  W   divisor
//   busy      out 1   high from the cycle after acceptance until done
//   done      out 1   one-cycle pulse; result/flags are valid from this cycle
//   result    out W   quotient, held until the next accepted start
//   flags     out 4   {invalid, div_by_zero, overflow, underflow}
//
// Optional build macro
//   FP_DIV_EARLY_EXIT_EN : special-case operands skip the divide loop, so
//                          done rises after edge 2 instead of MAN_W+5.
// -----------------------------------------------------------------------------
module fp_div_iter #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] operand_a,
    input  logic [W-1:0] operand_b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic [3:0]   flags
);

    localparam int QW  = MAN_W + 3;          // quotient bits
    localparam int RW  = MAN_W + 2;          // partial remainder bits
    localparam int EW2 = EXP_W + 2;          // signed working exponent
    localparam int CW  = $clog2(QW + 1);

    localparam logic [CW-1:0]         CNT_LAST = CW'(QW - 1);
    localparam logic signed [EW2-1:0] E_BIAS   = EW2'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [EW2-1:0] E_MAX    = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] E_ONE    = EW2'(1);
    localparam logic signed [EW2-1:0] E_ZERO   = {EW2{1'b0}};
    localparam logic [EXP_W-1:0]      EXP_ONES = {EXP_W{1'b1}};
    localparam logic [EXP_W-1:0]      EXP_ZERO = {EXP_W{1'b0}};
    localparam logic [MAN_W-1:0]      MAN_ZERO = {MAN_W{1'b0}};
    localparam logic [W-1:0]          QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_DIVIDE = 3'd2,
        S_NORM   = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state_r, state_nxt_s;
    logic                   busy_r, done_r, busy_nxt_s, done_nxt_s;
    logic                   accept_s;

    logic [W-1:0]           a_r, b_r, result_r, spec_res_r;
    logic [3:0]             flags_r, spec_flags_r;
    logic                   spec_r, sign_r;
    logic [RW-1:0]          rem_r;
    logic [MAN_W:0]         mb_r;
    logic [QW-1:0]          quo_r;
    logic [CW-1:0]          cnt_r;
    logic signed [EW2-1:0]  exp_r;

    logic [EXP_W-1:0]       ea_s, eb_s;
    logic [MAN_W-1:0]       fa_s, fb_s;
    logic                   a_zero_s, a_inf_s, a_nan_s, b_zero_s, b_inf_s, b_nan_s;
    logic                   sign_s, spec_s;
    logic [W-1:0]           spec_res_s;
    logic [3:0]             spec_flags_s;
    logic signed [EW2-1:0]  e_base_s;

    logic                   q_bit_s;
    logic [RW-2:0]          diff_s;
    logic [RW-1:0]          rem_nxt_s;

    logic [MAN_W:0]         q_al_s;          // {fraction, guard} after alignment
    logic                   sticky_s, round_up_s;
    logic [MAN_W:0]         frac_sum_s;
    logic signed [EW2-1:0]  e_adj_s, e_fin_s;
    logic [W-1:0]           norm_res_s;
    logic [3:0]             norm_flags_s;

    assign accept_s = start && !busy_r && ((state_r == S_IDLE) || (state_r == S_DONE));

    assign ea_s   = a_r[W-2:MAN_W];
    assign eb_s   = b_r[W-2:MAN_W];
    assign fa_s   = a_r[MAN_W-1:0];
    assign fb_s   = b_r[MAN_W-1:0];
    assign sign_s = a_r[W-1] ^ b_r[W-1];

    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;
    assign flags  = flags_r;

    // Operand classification and special-case result selection.
    always_comb begin
        a_zero_s     = (ea_s == EXP_ZERO);
        a_inf_s      = (ea_s == EXP_ONES) && (fa_s == MAN_ZERO);
        a_nan_s      = (ea_s == EXP_ONES) && (fa_s != MAN_ZERO);
        b_zero_s     = (eb_s == EXP_ZERO);
        b_inf_s      = (eb_s == EXP_ONES) && (fb_s == MAN_ZERO);
        b_nan_s      = (eb_s == EXP_ONES) && (fb_s != MAN_ZERO);
        spec_s       = 1'b1;
        spec_res_s   = {sign_s, {(W-1){1'b0}}};
        spec_flags_s = 4'b0000;
        if (a_nan_s || b_nan_s || (a_zero_s && b_zero_s) || (a_inf_s && b_inf_s)) begin
            spec_res_s   = QNAN;
            spec_flags_s = 4'b1000;
        end else if (a_inf_s) begin
            // inf / finite (including zero) is an exact infinity, no flag
            spec_res_s   = {sign_s, EXP_ONES, MAN_ZERO};
        end else if (b_zero_s) begin
            spec_res_s   = {sign_s, EXP_ONES, MAN_ZERO};
            spec_flags_s = 4'b0100;
        end else if (a_zero_s || b_inf_s) begin
            spec_res_s   = {sign_s, {(W-1){1'b0}}};
        end else begin
            spec_s       = 1'b0;
        end
        e_base_s = $signed({2'b00, ea_s}) - $signed({2'b00, eb_s}) + E_BIAS;
    end

    // One restoring-division step: compare, conditionally subtract, shift.
    always_comb begin
        q_bit_s = (rem_r >= {1'b0, mb_r});
        if (q_bit_s) begin
            // remainder after subtract is below the divisor, so the top bit drops safely
            diff_s = (RW-1)'(rem_r - {1'b0, mb_r});
        end else begin
            diff_s = rem_r[RW-2:0];
        end
        rem_nxt_s = {diff_s, 1'b0};
    end

    // Normalise, round to nearest-even and range-check the final quotient.
    always_comb begin
        sticky_s = (rem_r != {RW{1'b0}});
        if (quo_r[QW-1]) begin
            q_al_s   = quo_r[QW-2:1];
            sticky_s = sticky_s | quo_r[0];
            e_adj_s  = exp_r;
        end else begin
            q_al_s   = quo_r[QW-3:0];
            e_adj_s  = exp_r - E_ONE;
        end
        round_up_s = q_al_s[0] & (sticky_s | q_al_s[1]);
        // a carry out of the fraction leaves it all-zero, i.e. mantissa 1.0
        frac_sum_s = {1'b0, q_al_s[MAN_W:1]} + {{MAN_W{1'b0}}, round_up_s};
        e_fin_s    = e_adj_s + $signed({{(EW2-1){1'b0}}, frac_sum_s[MAN_W]});
        if (spec_r) begin
            norm_res_s   = spec_res_r;
            norm_flags_s = spec_flags_r;
        end else if (e_fin_s >= E_MAX) begin
            norm_res_s   = {sign_r, EXP_ONES, MAN_ZERO};
            norm_flags_s = 4'b0010;
        end else if (e_fin_s <= E_ZERO) begin
            norm_res_s   = {sign_r, {(W-1){1'b0}}};
            norm_flags_s = 4'b0001;
        end else begin
            norm_res_s   = {sign_r, e_fin_s[EXP_W-1:0], frac_sum_s[MAN_W-1:0]};
            norm_flags_s = 4'b0000;
        end
    end

    // FSM state register together with the registered handshake outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) state_nxt_s = S_CHECK;
                else          state_nxt_s = S_IDLE;
            end
            S_CHECK: begin
`ifdef FP_DIV_EARLY_EXIT_EN
                // special cases skip the loop; NORM only applies the override
                if (spec_s) state_nxt_s = S_NORM;
                else        state_nxt_s = S_DIVIDE;
`else
                state_nxt_s = S_DIVIDE;
`endif
            end
            S_DIVIDE: begin
                if (cnt_r == CNT_LAST) state_nxt_s = S_NORM;
                else                   state_nxt_s = S_DIVIDE;
            end
            S_NORM: state_nxt_s = S_DONE;
            S_DONE: begin
                if (accept_s) state_nxt_s = S_CHECK;
                else          state_nxt_s = S_IDLE;
            end
            default: state_nxt_s = S_IDLE;
        endcase
    end

    // FSM output decode of the next state, registered alongside the state.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (state_nxt_s)
            S_CHECK, S_DIVIDE, S_NORM: busy_nxt_s = 1'b1;
            S_DONE:                    done_nxt_s = 1'b1;
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Datapath: operand capture, classification, divide loop and result write.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r          <= {W{1'b0}};
            b_r          <= {W{1'b0}};
            result_r     <= {W{1'b0}};
            flags_r      <= 4'b0000;
            spec_res_r   <= {W{1'b0}};
            spec_flags_r <= 4'b0000;
            spec_r       <= 1'b0;
            sign_r       <= 1'b0;
            rem_r        <= {RW{1'b0}};
            mb_r         <= {(MAN_W+1){1'b0}};
            quo_r        <= {QW{1'b0}};
            cnt_r        <= {CW{1'b0}};
            exp_r        <= E_ZERO;
        end else begin
            if (accept_s) begin
                a_r      <= operand_a;
                b_r      <= operand_b;
                result_r <= {W{1'b0}};
                flags_r  <= 4'b0000;
            end
            case (state_r)
                S_CHECK: begin
                    spec_r       <= spec_s;
                    spec_res_r   <= spec_res_s;
                    spec_flags_r <= spec_flags_s;
                    sign_r       <= sign_s;
                    exp_r        <= e_base_s;
                    rem_r        <= {1'b0, 1'b1, fa_s};
                    mb_r         <= {1'b1, fb_s};
                    quo_r        <= {QW{1'b0}};
                    cnt_r        <= {CW{1'b0}};
                end
                S_DIVIDE: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= {quo_r[QW-2:0], q_bit_s};
                    cnt_r <= cnt_r + CW'(1);
                end
                S_NORM: begin
                    result_r <= norm_res_s;
                    flags_r  <= norm_flags_s;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_div_iter.sv
// -----------------------------------------------------------------------------
// tb_fp_div_iter
// Self-checking bench for fp_div_iter: a table of directed vectors, handshake
// sequences (ignored start, mid-operation reset, back-to-back issue), a
// half-precision instance, and randomized operands against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_fp_div_iter;

    localparam int LAT   = 28;
    localparam int LAT_H = 15;
`ifdef FP_DIV_EARLY_EXIT_EN
    localparam int LAT_SPEC = 2;
`else
    localparam int LAT_SPEC = 28;
`endif

    logic        clk = 1'b0;
    logic        rst, start, busy, done;
    logic [31:0] operand_a, operand_b, result;
    logic [3:0]  flags;

    logic        start_h, busy_h, done_h;
    logic [15:0] a_h, b_h, result_h;
    logic [3:0]  flags_h;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    fp_div_iter dut (
        .clk(clk), .rst(rst), .start(start),
        .operand_a(operand_a), .operand_b(operand_b),
        .busy(busy), .done(done), .result(result), .flags(flags)
    );

    fp_div_iter #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .start(start_h),
        .operand_a(a_h), .operand_b(b_h),
        .busy(busy_h), .done(done_h), .result(result_h), .flags(flags_h)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [3:0]  fl;
        bit          spec;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Reference: exact long-division quotient, then generic round-to-nearest-even.
    function automatic void ref_div(input int ew, input int mw, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] res,
                                    output logic [3:0] fl, output bit spec);
        longint unsigned emax, bias, ea, eb, fa, fb, ma, mb, num, q, rmd, half, m, sgn;
        longint e;
        int p, sh;
        bit az, ai, an, bz, bi, bn, st;
        emax = (64'd1 << ew) - 64'd1;
        bias = (64'd1 << (ew - 1)) - 64'd1;
        sgn  = 64'(a[ew+mw] ^ b[ew+mw]) << (ew + mw);
        ea = (64'(a) >> mw) & emax;
        eb = (64'(b) >> mw) & emax;
        fa = 64'(a) & ((64'd1 << mw) - 64'd1);
        fb = 64'(b) & ((64'd1 << mw) - 64'd1);
        az = (ea == 0); ai = (ea == emax) && (fa == 0); an = (ea == emax) && (fa != 0);
        bz = (eb == 0); bi = (eb == emax) && (fb == 0); bn = (eb == emax) && (fb != 0);
        spec = 1'b1;
        fl   = 4'b0000;
        if (an || bn || (az && bz) || (ai && bi)) begin
            res = 32'((emax << mw) | (64'd1 << (mw - 1)));
            fl  = 4'b1000;
        end else if (ai) begin
            res = 32'(sgn | (emax << mw));
        end else if (bz) begin
            res = 32'(sgn | (emax << mw));
            fl  = 4'b0100;
        end else if (az || bi) begin
            res = 32'(sgn);
        end else begin
            spec = 1'b0;
            ma  = (64'd1 << mw) | fa;
            mb  = (64'd1 << mw) | fb;
            num = ma << 36;
            q   = num / mb;
            st  = ((num % mb) != 0);
            p   = 0;
            for (int k = 0; k < 64; k++) if (q[k]) p = k;
            e    = longint'(ea) - longint'(eb) + longint'(bias) + longint'(p - 36);
            sh   = p - mw;
            m    = q >> sh;
            rmd  = q & ((64'd1 << sh) - 64'd1);
            half = 64'd1 << (sh - 1);
            if ((rmd > half) || ((rmd == half) && (st || m[0]))) m = m + 64'd1;
            if (m == (64'd1 << (mw + 1))) begin
                m = m >> 1;
                e = e + 1;
            end
            if (e >= longint'(emax)) begin
                res = 32'(sgn | (emax << mw));
                fl  = 4'b0010;
            end else if (e <= 0) begin
                res = 32'(sgn);
                fl  = 4'b0001;
            end else begin
                res = 32'(sgn | (64'(e) << mw) | (m & ((64'd1 << mw) - 64'd1)));
            end
        end
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [31:0] v;
        v = $urandom;
        case ($urandom_range(0, 9))
            0: v[30:23] = 8'h00;
            1: begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
            2: v[30:23] = 8'hFF;
            3: v[30:23] = 8'($urandom_range(1, 20));
            4: v[30:23] = 8'($urandom_range(235, 254));
            5: begin end
            default: v[30:23] = 8'($urandom_range(100, 154));
        endcase
        return v;
    endfunction

    // Issue one operation on the single-precision DUT and wait for done.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, output logic [31:0] res,
                          output logic [3:0] fl, output int lat, output logic busy_seen);
        @(negedge clk);
        operand_a = a; operand_b = b; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        busy_seen = busy;
        operand_a = $urandom; operand_b = $urandom;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin lat = n; break; end
        end
        res = result;
        fl  = flags;
    endtask

    task automatic run_op_h(input logic [15:0] a, input logic [15:0] b, output logic [15:0] res,
                            output logic [3:0] fl, output int lat);
        @(negedge clk);
        a_h = a; b_h = b; start_h = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_h = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done_h) begin lat = n; break; end
        end
        res = result_h;
        fl  = flags_h;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r, er;
        logic [3:0]  f, ef;
        logic [15:0] rh;
        logic        bsy;
        bit          es;
        int          lat, dones;

        vecs[0]  = '{32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 1'b0};
        vecs[1]  = '{32'hBFC00000, 32'h3F000000, 32'hC0400000, 4'b0000, 1'b0};
        vecs[2]  = '{32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000, 1'b0};
        vecs[3]  = '{32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 1'b0};
        vecs[4]  = '{32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0100, 1'b1};
        vecs[5]  = '{32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[6]  = '{32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[7]  = '{32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000, 1'b1};
        vecs[8]  = '{32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 1'b0};
        vecs[9]  = '{32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 1'b0};
        vecs[10] = '{32'h7FC00001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1'b1};
        vecs[11] = '{32'hC0000000, 32'h80000000, 32'h7F800000, 4'b0100, 1'b1};
        vecs[12] = '{32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1'b1};
        vecs[13] = '{32'h00400000, 32'h3F800000, 32'h00000000, 4'b0000, 1'b1};
        vecs[14] = '{32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1'b1};

        rst = 1'b1; start = 1'b0; operand_a = 32'd0; operand_b = 32'd0;
        start_h = 1'b0; a_h = 16'd0; b_h = 16'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 32'd0);
        chk("reset_flags", flags, 4'd0);
        chk("reset_result_h", result_h, 16'd0);
        rst = 1'b0;

        // Directed table
        for (int i = 0; i < 15; i++) begin
            run_op(vecs[i].a, vecs[i].b, r, f, lat, bsy);
            chk($sformatf("vec%0d_result", i), r, vecs[i].res);
            chk($sformatf("vec%0d_flags", i), f, vecs[i].fl);
            chk($sformatf("vec%0d_latency", i), lat, vecs[i].spec ? LAT_SPEC : LAT);
            chk($sformatf("vec%0d_busy", i), bsy, 1'b1);
        end

        // start at edge 5 of an active operation is ignored
        @(negedge clk);
        operand_a = 32'h40C00000; operand_b = 32'h40000000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            if (n == 5) begin
                start = 1'b1; operand_a = 32'h3F800000; operand_b = 32'h40400000;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
            if (done) begin lat = n; break; end
        end
        start = 1'b0;
        chk("ignored_start_result", result, 32'h40400000);
        chk("ignored_start_latency", lat, LAT);
        @(posedge clk);
        @(negedge clk);
        chk("done_single_cycle", done, 1'b0);
        chk("result_held", result, 32'h40400000);

        // Back-to-back: start accepted in the DONE cycle
        run_op(32'h40C00000, 32'h40000000, r, f, lat, bsy);
        chk("b2b_first_result", r, 32'h40400000);
        operand_a = 32'h3F800000; operand_b = 32'h40400000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accepted_busy", busy, 1'b1);
        chk("b2b_result_cleared", result, 32'd0);
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin lat = n; break; end
        end
        chk("b2b_second_latency", lat, LAT);
        chk("b2b_second_result", result, 32'h3EAAAAAB);

        // Reset at edge 10 of an active operation
        @(negedge clk);
        operand_a = 32'h40C00000; operand_b = 32'h40000000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (9) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_done", done, 1'b0);
        chk("midrst_result", result, 32'd0);
        chk("midrst_flags", flags, 4'd0);
        rst = 1'b0;
        dones = 0;
        repeat (60) begin
            @(posedge clk);
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst_no_done", dones, 0);

        // Half-precision instance
        run_op_h(16'h3C00, 16'h4000, rh, f, lat);
        chk("half_result", rh, 16'h3800);
        chk("half_flags", f, 4'd0);
        chk("half_latency", lat, LAT_H);
        run_op_h(16'h3C00, 16'h4200, rh, f, lat);
        chk("half_third_result", rh, 16'h3555);
        chk("half_third_latency", lat, LAT_H);

        // Randomized operands against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ra, rb;
            ra = rand_fp();
            rb = rand_fp();
            ref_div(8, 23, ra, rb, er, ef, es);
            run_op(ra, rb, r, f, lat, bsy);
            chk($sformatf("rand%0d_result a=%0h b=%0h", i, ra, rb), r, er);
            chk($sformatf("rand%0d_flags", i), f, ef);
            chk($sformatf("rand%0d_latency", i), lat, es ? LAT_SPEC : LAT);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
